// File: rtl/bomb_ctrl.sv
// Bomb placement, fuse, blast and cooldown sequencer.
// Every output is registered; blast rectangles are non-zero only while in BLAST.
module bomb_ctrl #(
    parameter int FUSE_FRAMES  = 120,
    parameter int BLAST_FRAMES = 30,
    parameter int COOL_FRAMES  = 15,
    parameter int RANGE        = 1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       bomb_drop,
    input  logic [9:0] userX,
    input  logic [9:0] userY,
    output logic       bomb_active,
    output logic [9:0] bombX,
    output logic [9:0] bombY,
    output logic [9:0] blastHX,
    output logic [9:0] blastHY,
    output logic [9:0] blastHXS,
    output logic [9:0] blastHYS,
    output logic [9:0] blastVX,
    output logic [9:0] blastVY,
    output logic [9:0] blastVXS,
    output logic [9:0] blastVYS,
    output logic       explode,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        BLAST,
        COOL
    } state_t;

    localparam logic [7:0]  FUSE_LD  = 8'(FUSE_FRAMES - 1);
    localparam logic [7:0]  BLAST_LD = 8'(BLAST_FRAMES - 1);
    localparam logic [7:0]  COOL_LD  = 8'(COOL_FRAMES - 1);
    localparam logic [10:0] REACH    = 11'(32 * RANGE);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       drop_q;
    logic       active_q;
    logic       busy_q;
    logic       explode_q;
    logic [9:0] bx_q;
    logic [9:0] by_q;
    logic [9:0] hx_q;
    logic [9:0] hy_q;
    logic [9:0] hxs_q;
    logic [9:0] hys_q;
    logic [9:0] vx_q;
    logic [9:0] vy_q;
    logic [9:0] vxs_q;
    logic [9:0] vys_q;

    logic        drop_edge;
    logic [10:0] sx;
    logic [10:0] sy;
    logic [10:0] tx;
    logic [10:0] ty;
    logic [9:0]  bx_d;
    logic [9:0]  by_d;
    logic [9:0]  h_start;
    logic [9:0]  h_end;
    logic [10:0] h_end_raw;
    logic [9:0]  v_start;
    logic [9:0]  v_end;
    logic [10:0] v_end_raw;

    assign drop_edge = bomb_drop & ~drop_q;

    // Snap the player's approximate centre to its 32-px tile.
    always_comb begin
        sx = {1'b0, userX} + 11'd10;
        sy = {1'b0, userY} + 11'd13;
        tx = {sx[10:5], 5'b0};
        ty = {sy[10:5], 5'b0};
        bx_d = tx[9:0];
        by_d = ty[9:0];
        if (tx < 11'd32)
            bx_d = 10'd32;
        else if (tx > 11'd576)
            bx_d = 10'd576;
        if (ty < 11'd32)
            by_d = 10'd32;
        else if (ty > 11'd416)
            by_d = 10'd416;
    end

    // Compare before subtracting so the low clamp never wraps.
    always_comb begin
        h_start = 10'd32;
        v_start = 10'd32;
        if ({1'b0, bx_q} >= REACH + 11'd32)
            h_start = bx_q - REACH[9:0];
        if ({1'b0, by_q} >= REACH + 11'd32)
            v_start = by_q - REACH[9:0];
        h_end_raw = {1'b0, bx_q} + 11'd32 + REACH;
        v_end_raw = {1'b0, by_q} + 11'd32 + REACH;
        h_end = h_end_raw[9:0];
        v_end = v_end_raw[9:0];
        if (h_end_raw > 11'd608)
            h_end = 10'd608;
        if (v_end_raw > 11'd448)
            v_end = 10'd448;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            active_q  <= 1'b0;
            busy_q    <= 1'b0;
            explode_q <= 1'b0;
            bx_q      <= '0;
            by_q      <= '0;
            hx_q      <= '0;
            hy_q      <= '0;
            hxs_q     <= '0;
            hys_q     <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            vxs_q     <= '0;
            vys_q     <= '0;
        end else begin
            drop_q    <= bomb_drop;
            explode_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (drop_edge) begin
                        state_q  <= ARMED;
                        cnt_q    <= FUSE_LD;
                        bx_q     <= bx_d;
                        by_q     <= by_d;
                        active_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ARMED: begin
                    if (cnt_q == 8'd0) begin
                        state_q   <= BLAST;
                        cnt_q     <= BLAST_LD;
                        explode_q <= 1'b1;
                        hx_q      <= h_start;
                        hy_q      <= by_q;
                        hxs_q     <= h_end - h_start;
                        hys_q     <= 10'd32;
                        vx_q      <= bx_q;
                        vy_q      <= v_start;
                        vxs_q     <= 10'd32;
                        vys_q     <= v_end - v_start;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                BLAST: begin
                    if (cnt_q == 8'd0) begin
                        active_q <= 1'b0;
                        hx_q     <= '0;
                        hy_q     <= '0;
                        hxs_q    <= '0;
                        hys_q    <= '0;
                        vx_q     <= '0;
                        vy_q     <= '0;
                        vxs_q    <= '0;
                        vys_q    <= '0;
                        if (COOL_FRAMES == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= COOL;
                            cnt_q   <= COOL_LD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                COOL: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bomb_active = active_q;
    assign busy        = busy_q;
    assign explode     = explode_q;
    assign bombX       = bx_q;
    assign bombY       = by_q;
    assign blastHX     = hx_q;
    assign blastHY     = hy_q;
    assign blastHXS    = hxs_q;
    assign blastHYS    = hys_q;
    assign blastVX     = vx_q;
    assign blastVY     = vy_q;
    assign blastVXS    = vxs_q;
    assign blastVYS    = vys_q;

endmodule

// File: tb/tb_bomb_ctrl.sv
// Directed bench for bomb_ctrl: default timing instance plus a
// short-fuse instance with no cooldown.
module tb_bomb_ctrl;

    logic       clk;
    logic       rst;
    logic       drop;
    logic       drop2;
    logic [9:0] ux;
    logic [9:0] uy;

    logic       act;
    logic       exp1;
    logic       busy;
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] hx;
    logic [9:0] hy;
    logic [9:0] hxs;
    logic [9:0] hys;
    logic [9:0] vx;
    logic [9:0] vy;
    logic [9:0] vxs;
    logic [9:0] vys;

    logic       act2;
    logic       exp2;
    logic       busy2;
    logic [9:0] bx2;
    logic [9:0] by2;
    logic [9:0] hx2;
    logic [9:0] hy2;
    logic [9:0] hxs2;
    logic [9:0] hys2;
    logic [9:0] vx2;
    logic [9:0] vy2;
    logic [9:0] vxs2;
    logic [9:0] vys2;

    int n_chk;
    int n_pass;
    int exp_cnt;
    int n;

    bomb_ctrl dut (
        .frame_clk  (clk),
        .Reset      (rst),
        .bomb_drop  (drop),
        .userX      (ux),
        .userY      (uy),
        .bomb_active(act),
        .bombX      (bx),
        .bombY      (by),
        .blastHX    (hx),
        .blastHY    (hy),
        .blastHXS   (hxs),
        .blastHYS   (hys),
        .blastVX    (vx),
        .blastVY    (vy),
        .blastVXS   (vxs),
        .blastVYS   (vys),
        .explode    (exp1),
        .busy       (busy)
    );

    bomb_ctrl #(
        .FUSE_FRAMES (4),
        .BLAST_FRAMES(3),
        .COOL_FRAMES (0),
        .RANGE       (1)
    ) dut2 (
        .frame_clk  (clk),
        .Reset      (rst),
        .bomb_drop  (drop2),
        .userX      (ux),
        .userY      (uy),
        .bomb_active(act2),
        .bombX      (bx2),
        .bombY      (by2),
        .blastHX    (hx2),
        .blastHY    (hy2),
        .blastHXS   (hxs2),
        .blastHYS   (hys2),
        .blastVX    (vx2),
        .blastVY    (vy2),
        .blastVXS   (vxs2),
        .blastVYS   (vys2),
        .explode    (exp2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got == want)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (exp1)
                exp_cnt++;
        end
    endtask

    // Leaves the bench at the first BLAST cycle; returns fuse length seen.
    task automatic wait_explode(output int cycles);
        cycles = 0;
        while (!exp1 && cycles < 300) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 300) begin
            step(1);
            k++;
        end
        check(tag, int'(busy), 0);
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        exp_cnt = 0;
        rst     = 1'b1;
        drop    = 1'b0;
        drop2   = 1'b0;
        ux      = 10'd100;
        uy      = 10'd200;
        step(2);
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_active", int'(act), 0);
        check("rst_bombX", int'(bx), 0);
        check("rst_explode", int'(exp1), 0);
        check("rst_HXS", int'(hxs), 0);

        // No-cooldown instance: 4 fuse + 3 blast, then straight to IDLE.
        drop2 = 1'b1;
        step(1);
        drop2 = 1'b0;
        check("c0_busy_arm", int'(busy2), 1);
        step(6);
        check("c0_last_blast", int'(act2), 1);
        check("c0_busy_blast", int'(busy2), 1);
        step(1);
        check("c0_busy_fall", int'(busy2), 0);
        check("c0_active_fall", int'(act2), 0);

        // Basic drop and geometry.
        exp_cnt = 0;
        drop = 1'b1;
        step(1);
        drop = 1'b0;
        check("drop_active", int'(act), 1);
        check("drop_bombX", int'(bx), 96);
        check("drop_bombY", int'(by), 192);
        check("armed_HX_zero", int'(hx), 0);
        wait_explode(n);
        check("fuse_len", n, 120);
        check("HX", int'(hx), 64);
        check("HXS", int'(hxs), 96);
        check("HY", int'(hy), 192);
        check("HYS", int'(hys), 32);
        check("VX", int'(vx), 96);
        check("VY", int'(vy), 160);
        check("VXS", int'(vxs), 32);
        check("VYS", int'(vys), 96);
        step(1);
        check("explode_once", int'(exp1), 0);
        step(28);
        check("blast_last_active", int'(act), 1);
        step(1);
        check("cool_active", int'(act), 0);
        check("cool_busy", int'(busy), 1);
        check("cool_HXS", int'(hxs), 0);
        check("cool_VYS", int'(vys), 0);
        check("explode_count", exp_cnt, 1);

        // Edge in COOL is dropped; edge right after IDLE is taken.
        ux = 10'd300;
        drop = 1'b1;
        step(1);
        drop = 1'b0;
        step(1);
        check("cool_edge_ignored", int'(act), 0);
        check("cool_bombX_hold", int'(bx), 96);
        wait_idle("cool_end");
        ux = 10'd32;
        uy = 10'd32;
        drop = 1'b1;
        step(1);
        drop = 1'b0;
        check("redrop_active", int'(act), 1);
        check("corner_bombX", int'(bx), 32);
        check("corner_bombY", int'(by), 32);
        wait_explode(n);
        check("corner_fuse", n, 120);
        check("corner_HX", int'(hx), 32);
        check("corner_HXS", int'(hxs), 64);
        check("corner_VY", int'(vy), 32);
        check("corner_VYS", int'(vys), 64);
        wait_idle("corner_end");

        // Held key: exactly one bomb across 300 cycles.
        ux = 10'd100;
        uy = 10'd200;
        exp_cnt = 0;
        drop = 1'b1;
        step(300);
        check("held_explodes", exp_cnt, 1);
        check("held_busy_end", int'(busy), 0);
        drop = 1'b0;
        step(2);

        // Reset in ARMED cycle 50 aborts without explode.
        exp_cnt = 0;
        drop = 1'b1;
        step(1);
        drop = 1'b0;
        step(49);
        check("abort_pre_active", int'(act), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_active", int'(act), 0);
        check("abort_bombX", int'(bx), 0);
        step(200);
        check("abort_no_explode", exp_cnt, 0);
        drop = 1'b1;
        step(1);
        drop = 1'b0;
        check("post_abort_bombX", int'(bx), 96);
        wait_explode(n);
        check("post_abort_fuse", n, 120);
        wait_idle("post_abort_end");

        // Reset coinciding with a drop edge.
        rst  = 1'b1;
        drop = 1'b1;
        step(1);
        rst  = 1'b0;
        drop = 1'b0;
        step(1);
        check("rst_wins_busy", int'(busy), 0);
        check("rst_wins_active", int'(act), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bomb_ctrl.md
BOMB_CTRL -- requirements
Module: bomb_ctrl

Interface
REQ-001 SHALL have parameter FUSE_FRAMES, default 120, frames between placement and detonation (1..255).
REQ-002 SHALL have parameter BLAST_FRAMES, default 30, frames the blast stays live (1..255).
REQ-003 SHALL have parameter COOL_FRAMES, default 15, frames after the blast before another drop is accepted (0..255).
REQ-004 SHALL have parameter RANGE, default 1, blast reach in 32-px tiles on each side of the bomb (1..3).
REQ-005 SHALL have ports: frame_clk in 1, the only clock; Reset in 1, synchronous, active-high.
REQ-006 SHALL have ports: bomb_drop in 1, drop request from the player block; userX, userY in 10, the player's top-left pixel.
REQ-007 SHALL have ports: bomb_active out 1, bomb on the map; bombX, bombY out 10, bomb tile top-left.
REQ-008 SHALL have ports: blastHX, blastHY, blastHXS, blastHYS out 10, the horizontal blast rectangle (position, size).
REQ-009 SHALL have ports: blastVX, blastVY, blastVXS, blastVYS out 10, the vertical blast rectangle.
REQ-010 SHALL have ports: explode out 1, one-cycle detonation pulse; busy out 1, high in any state other than IDLE.

Function
REQ-011 SHALL implement a 4-state FSM: IDLE, ARMED, BLAST, COOL.
REQ-012 SHALL accept a drop only on a bomb_drop rising edge (registered previous value); holding bomb_drop high counts as one drop.
REQ-013 SHALL ignore drop edges in ARMED, BLAST and COOL; no queuing.
REQ-014 SHALL latch the tile on an accepted edge: bombX = ((userX+10)>>5)<<5 and bombY = ((userY+13)>>5)<<5, with each coordinate clamped to the range 32..576 (X) and 32..416 (Y).
REQ-015 SHALL go IDLE->ARMED in the cycle after the edge is sampled and stay in ARMED for exactly FUSE_FRAMES cycles, counted by an 8-bit down counter.
REQ-016 SHALL go ARMED->BLAST when the fuse count expires, raise explode in the first BLAST cycle only, and stay in BLAST for exactly BLAST_FRAMES cycles.
REQ-017 SHALL go BLAST->COOL for COOL_FRAMES cycles, then enter IDLE; when COOL_FRAMES=0, SHALL go BLAST->IDLE directly.
REQ-018 SHALL hold bomb_active high in ARMED and BLAST and low in IDLE and COOL; bombX/bombY SHALL hold their value until the next accepted drop.
REQ-019 SHALL compute the horizontal rectangle in BLAST as follows: start = max(bombX-32*RANGE, 32); end = min(bombX+32+32*RANGE, 608); HX = start; HXS = end-start; HY = bombY; HYS = 32.
REQ-020 SHALL compute the vertical rectangle in BLAST as follows: start = max(bombY-32*RANGE, 32); end = min(bombY+32+32*RANGE, 448); VY = start; VYS = end-start; VX = bombX; VXS = 32.
REQ-021 SHALL apply the clamps using compare-before-subtract so that no 10-bit underflow occurs.
REQ-022 SHALL drive all blast outputs to 0 outside BLAST, so that a zero-size rectangle never registers a hit.
REQ-023 SHALL register all outputs (no combinational path from input to output); blast rectangles SHALL be valid in the same cycle the state is BLAST.
REQ-024 SHALL give priority to expiry when a drop edge coincides with ARMED expiry or COOL expiry: the edge is ignored and the drop must be re-pressed.

Reset
REQ-025 SHALL, when Reset=1 at a frame_clk edge, put the FSM in IDLE, clear the counters and the edge register, and drive all outputs to 0.
REQ-026 SHALL abort any bomb or blast on Reset mid-ARMED/BLAST/COOL, with no explode pulse.
REQ-027 SHALL let Reset win when it coincides with a drop edge: the design stays in IDLE.

Verification
REQ-028 Basic drop: userX=100, userY=200, bomb_drop pulses for 1 cycle -> bombX=96, bombY=192, bomb_active high for 120+30 cycles, explode exactly once, 120 cycles after ARMED entry.
REQ-029 Blast geometry (same bomb) -> HX=64, HXS=96, HY=192, HYS=32; VX=96, VY=160, VXS=32, VYS=96; all zero after 30 cycles.
REQ-030 Corner clamp: userX=32, userY=32 -> bomb at (32,32); HX=32, HXS=64; VY=32, VYS=64.
REQ-031 Held key and re-drop: bomb_drop held high 300 cycles -> one bomb only; a new edge during COOL is ignored; a new edge 1 cycle after IDLE is re-entered is accepted.
REQ-032 Reset at ARMED cycle 50 -> next cycle is IDLE, all outputs 0, explode never asserted; a following drop behaves like REQ-028.
REQ-033 COOL_FRAMES=0: BLAST goes directly to IDLE; busy falls immediately after the last BLAST cycle.
